mac_accumulator: RTL



---
 rtl/mac_accumulator.sv | 109 ++++++++++
 1 files changed

// File: rtl/mac_accumulator.sv
// mac_accumulator: accumulates a run of 1..16 unsigned 16-bit products into a
// 20-bit sum and presents the result with a valid/ready handshake.
// Build option: define MAC_PIPE_EN to register prod/valid between the input
// handshake and the adder. This adds one cycle of result latency.
module mac_accumulator (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  len,
  input  logic [15:0] prod,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [19:0] acc_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  total;
  logic [4:0]  accepted;
  logic [4:0]  added;
  logic [19:0] acc;
  logic        beat;
  logic        load;
  logic        add_en;
  logic        add_last;
  logic [15:0] add_prod;

  assign in_ready = (state == ACC) && (accepted < total);
  assign beat     = in_valid && in_ready;
  assign load     = start && ((state == IDLE) || ((state == DONE) && out_ready));

`ifdef MAC_PIPE_EN
  logic        pipe_valid;
  logic [15:0] pipe_prod;

  // One-deep register between the handshake and the adder
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid <= 1'b0;
      pipe_prod  <= '0;
    end else if (load) begin
      pipe_valid <= 1'b0;
    end else begin
      pipe_valid <= beat;
      if (beat) pipe_prod <= prod;
    end
  end

  assign add_en   = pipe_valid;
  assign add_prod = pipe_prod;
`else
  assign add_en   = beat;
  assign add_prod = prod;
`endif

  // The run completes on the add that brings the added count up to total.
  assign add_last = add_en && ((added + 5'd1) == total);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACC;
      ACC:     if (add_last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = start ? ACC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Run length, beat counters and the accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total    <= '0;
      accepted <= '0;
      added    <= '0;
      acc      <= '0;
    end else if (load) begin
      total    <= (len == 4'd0) ? 5'd16 : {1'b0, len};
      accepted <= '0;
      added    <= '0;
      acc      <= '0;
    end else if ((state == DONE) && out_ready) begin
      accepted <= '0;
      added    <= '0;
      acc      <= '0;
    end else begin
      if (beat)   accepted <= accepted + 5'd1;
      if (add_en) begin
        added <= added + 5'd1;
        acc   <= acc + {4'b0000, add_prod};
      end
    end
  end

  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign acc_out   = out_valid ? acc : '0;

endmodule
